// File: rtl/ldm_stm_seq_if.sv
// ldm_stm_seq_if
//   Bundles the issue, regfile and memory signals of the LDM/STM sequencer.
//   master : the sequencer (drives regfile selects/strobes and the memory bus)
//   slave  : the environment (issue logic, register file, data memory)
//
// Handshake: a memory beat is offered while mem_req=1; mem_addr, mem_we and
// mem_wdata stay stable until a rising edge samples mem_ack=1 with mem_req=1,
// which completes the beat (mem_rdata is valid in that same cycle). mem_ack
// is a don't-care whenever mem_req=0. start is only looked at while the
// sequencer is idle; done (and error, on timeout) are one-cycle pulses.
interface ldm_stm_seq_if;
  logic        start;
  logic        is_load;
  logic        up;
  logic        pre;
  logic [15:0] reg_list;
  logic [3:0]  base_sel;
  logic [31:0] base_addr;
  logic [3:0]  rf_sel_p0;
  logic [31:0] rf_p0;
  logic [3:0]  rf_sel_in;
  logic        rf_in_enable;
  logic [31:0] rf_in_reg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, is_load, up, pre, reg_list, base_sel, base_addr,
    input  rf_p0, mem_rdata, mem_ack,
    output rf_sel_p0, rf_sel_in, rf_in_enable, rf_in_reg,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, done, error
  );

  modport slave (
    output start, is_load, up, pre, reg_list, base_sel, base_addr,
    output rf_p0, mem_rdata, mem_ack,
    input  rf_sel_p0, rf_sel_in, rf_in_enable, rf_in_reg,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, done, error
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq
//   Multi-register transfer sequencer (ARM LDM/STM). Walks reg_list from the
//   lowest set bit upward, one memory beat per set bit; the lowest register
//   always maps to the lowest address. Owns both regfile ports while busy.
//
// Ports
//   i_clock      : system clock, rising edge
//   i_reset      : synchronous, active-high reset
//   bus          : ldm_stm_seq_if.master (issue, regfile and memory signals)
//   o_dbg_state  : current FSM state (0 IDLE, 1 XFER, 2 WB, 3 FINISH)
//
// Parameters
//   ADDR_STEP    : byte increment per transferred word
//   ACK_TIMEOUT  : max wait cycles for mem_ack per beat, 0 = wait forever
//
// Build option
//   BASE_WRITEBACK_EN : when defined, the final base address is written to
//   base_sel after the last beat (skipped for a load whose list contains the
//   base register, so the loaded value wins).
module ldm_stm_seq #(
  parameter int ADDR_STEP   = 4,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  ldm_stm_seq_if.master bus,
  output logic [1:0]   o_dbg_state
);

`ifdef BASE_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_WB = 2'd2, S_FINISH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_FINISH = 2'd3} state_t;
`endif

  localparam logic [31:0] STEP    = 32'(ADDR_STEP);
  localparam logic [15:0] TO_LAST = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  logic [15:0] r_list;
  logic [31:0] r_addr;
  logic        r_load;
  logic        r_we;
  logic        r_mem_req;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_wait;
`ifdef BASE_WRITEBACK_EN
  logic [31:0] r_final;
  logic [3:0]  r_base_sel;
  logic        r_skip_wb;
`endif

  logic [4:0]  w_n;
  logic [31:0] w_span;
  logic [31:0] w_first;
  logic [3:0]  w_cur;
  logic [15:0] w_list_next;
  logic        w_ack;
  logic        w_timeout;
  logic        w_ld_wr;
  logic        w_wb;

  // Number of registers in the incoming list and the byte span they cover.
  always_comb begin
    w_n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_n = w_n + {4'd0, bus.reg_list[i]};
    end
  end
  assign w_span = STEP * {27'd0, w_n};

  // Descending modes start at the bottom of the block so the lowest register
  // still lands at the lowest address and every beat adds STEP.
  always_comb begin
    case ({bus.up, bus.pre})
      2'b10:   w_first = bus.base_addr;
      2'b11:   w_first = bus.base_addr + STEP;
      2'b00:   w_first = bus.base_addr - w_span + STEP;
      default: w_first = bus.base_addr - w_span;
    endcase
  end

  // Lowest set bit of the remaining list is the register for this beat.
  always_comb begin
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) w_cur = 4'(i);
    end
  end
  assign w_list_next = r_list & (r_list - 16'd1);

  assign w_ack     = (r_state == S_XFER) && bus.mem_ack;
  assign w_timeout = (ACK_TIMEOUT > 0) && (r_state == S_XFER) && !bus.mem_ack && (r_wait == TO_LAST);
  assign w_ld_wr   = w_ack && r_load;
`ifdef BASE_WRITEBACK_EN
  assign w_wb      = (r_state == S_WB);
`else
  assign w_wb      = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_list    <= 16'd0;
      r_addr    <= 32'd0;
      r_load    <= 1'b0;
      r_we      <= 1'b0;
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_wait    <= 16'd0;
`ifdef BASE_WRITEBACK_EN
      r_final    <= 32'd0;
      r_base_sel <= 4'd0;
      r_skip_wb  <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_list <= bus.reg_list;
            r_addr <= w_first;
            r_load <= bus.is_load;
            r_wait <= 16'd0;
`ifdef BASE_WRITEBACK_EN
            r_final    <= bus.up ? (bus.base_addr + w_span) : (bus.base_addr - w_span);
            r_base_sel <= bus.base_sel;
            r_skip_wb  <= bus.is_load && bus.reg_list[bus.base_sel];
`endif
            if (bus.reg_list == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_mem_req <= 1'b1;
              r_we      <= !bus.is_load;
              r_busy    <= 1'b1;
              r_state   <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (w_ack) begin
            r_list <= w_list_next;
            r_addr <= r_addr + STEP;
            r_wait <= 16'd0;
            if (w_list_next == 16'd0) begin
              r_mem_req <= 1'b0;
              r_we      <= 1'b0;
`ifdef BASE_WRITEBACK_EN
              if (!r_skip_wb) begin
                r_state <= S_WB;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end
`else
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
`endif
            end
          end else if (w_timeout) begin
            // Abandon the transfer: no further beats and no base update.
            r_list    <= 16'd0;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
`ifdef BASE_WRITEBACK_EN
        S_WB: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FINISH;
        end
`endif
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Load data is forwarded to the write port in the ack cycle itself, so the
  // write strobe is decoded from state plus mem_ack rather than registered.
  assign bus.rf_sel_p0    = w_cur;
  assign bus.mem_wdata    = bus.rf_p0;
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.rf_in_enable = w_ld_wr || w_wb;
`ifdef BASE_WRITEBACK_EN
  assign bus.rf_sel_in    = w_wb ? r_base_sel : w_cur;
  assign bus.rf_in_reg    = w_wb ? r_final : bus.mem_rdata;
`else
  assign bus.rf_sel_in    = w_cur;
  assign bus.rf_in_reg    = bus.mem_rdata;
`endif
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign o_dbg_state      = r_state;

endmodule
